// File: rtl/spike_event_tx_pkg.sv
// Shared definitions for the spike event transmitter: channel FSM encoding
// and default sizing parameters.
package spike_event_tx_pkg;

  localparam int unsigned N_CH_DEF   = 8;
  localparam int unsigned PEND_W_DEF = 3;
  localparam int unsigned DROP_W_DEF = 16;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_REQ  = 2'd1,
    CH_REL  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/spike_tx_channel.sv
// One transmit channel: a saturating pending-spike counter feeding a
// four-phase request/acknowledge FSM.
module spike_tx_channel
  import spike_event_tx_pkg::*;
#(
  parameter int unsigned PEND_W = PEND_W_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic spike,
  input  logic ack,
  output logic req,
  output logic drop,
  output logic active,
  output logic ack_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  ch_state_e         state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              req_q;
  logic              dec;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    drop    = 1'b0;
    dec     = (state_q == CH_REQ) && ack;

    if (spike && !dec) begin
      if (pend_q == PEND_MAX) drop = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (dec && !spike) begin
      pend_d = pend_q - 1'b1;
    end

    case (state_q)
      CH_IDLE: if ((pend_q != '0) || spike) state_d = CH_REQ;
      CH_REQ:  if (ack)                     state_d = CH_REL;
      CH_REL:  if (!ack)                    state_d = CH_IDLE;
      default:                              state_d = CH_IDLE;
    endcase
  end

  // Request line is registered from the next state so it tracks REQ exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= CH_IDLE;
      pend_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      req_q   <= (state_d == CH_REQ);
    end
  end

  assign req     = req_q;
  assign active  = (pend_q != '0) || (state_q != CH_IDLE);
  assign ack_err = ack && (state_q == CH_IDLE);

endmodule

// File: rtl/spike_event_tx.sv
// Spike event transmitter: N_CH independent handshake channels with
// aggregated drop counting, busy and sticky protocol-error reporting.
module spike_event_tx
  import spike_event_tx_pkg::*;
#(
  parameter int unsigned N_CH   = N_CH_DEF,
  parameter int unsigned PEND_W = PEND_W_DEF,
  parameter int unsigned DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_CH-1:0]   spike_pulse_in,
  input  logic [N_CH-1:0]   acks_in,
  output logic [N_CH-1:0]   spikes_out,
  output logic [DROP_W-1:0] drop_count,
  output logic              busy,
  output logic              proto_err
);

  localparam int unsigned SUM_W = $clog2(N_CH + 1);

  logic [N_CH-1:0]   drop_v;
  logic [N_CH-1:0]   active_v;
  logic [N_CH-1:0]   ack_err_v;
  logic [SUM_W-1:0]  drop_sum;
  logic [DROP_W:0]   drop_nxt;
  logic [DROP_W-1:0] drop_q;
  logic              proto_q;
  logic              multi_ack;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    spike_tx_channel #(
      .PEND_W(PEND_W)
    ) u_ch (
      .clk    (clk),
      .resetn (resetn),
      .spike  (spike_pulse_in[g]),
      .ack    (acks_in[g]),
      .req    (spikes_out[g]),
      .drop   (drop_v[g]),
      .active (active_v[g]),
      .ack_err(ack_err_v[g])
    );
  end

  always_comb begin
    drop_sum = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      drop_sum = drop_sum + SUM_W'(drop_v[i]);
    end
    drop_nxt  = {1'b0, drop_q} + (DROP_W + 1)'(drop_sum);
    multi_ack = (acks_in & (acks_in - N_CH'(1))) != '0;
  end

  // Extra carry bit detects overflow so the count pins at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_q  <= '0;
      proto_q <= 1'b0;
    end else begin
      drop_q  <= drop_nxt[DROP_W] ? '1 : drop_nxt[DROP_W-1:0];
      proto_q <= proto_q | (|ack_err_v) | multi_ack;
    end
  end

  assign drop_count = drop_q;
  assign busy       = |active_v;
  assign proto_err  = proto_q;

endmodule
